// File: rtl/snake_pkg.sv
// Shared types and constants for the two-snake game round scheduler.
package snake_pkg;

  localparam int DEF_NUM_LEN = 10;
  localparam int DEF_MAX_LEN = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_MOVE,
    S_SETTLE,
    S_SCAN,
    S_RESOLVE,
    S_OVER
  } sched_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/snake_seg_mux.sv
// Picks the NUM_LEN-bit segment at index idx out of a packed snake body.
module snake_seg_mux #(
  parameter int MAX_LEN = 31,
  parameter int NUM_LEN = 10,
  parameter int LEN_W   = 5
) (
  input  logic [MAX_LEN*NUM_LEN-1:0] body,
  input  logic [LEN_W-1:0]           idx,
  output logic [NUM_LEN-1:0]         seg
);

  // Out-of-range indices read as zero rather than wrapping.
  always_comb begin
    seg = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == LEN_W'(i)) seg = body[i*NUM_LEN +: NUM_LEN];
    end
  end

endmodule

// File: rtl/snake_round_sched.sv
// Move-tick scheduler: pulses the movers once per tick, then serially scans
// both bodies for collisions and resolves death, game-over and winner.
module snake_round_sched
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int NUM_LEN  = DEF_NUM_LEN,
  parameter int LEN_W    = 5,
  parameter int TICK_DIV = 5_000_000,
  parameter int TICK_W   = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pause,
  input  logic [MAX_LEN*NUM_LEN-1:0] snake1,
  input  logic [MAX_LEN*NUM_LEN-1:0] snake2,
  input  logic [LEN_W-1:0]           len1,
  input  logic [LEN_W-1:0]           len2,
  output logic                       move_en,
  output logic                       busy,
  output logic                       dead1,
  output logic                       dead2,
  output logic                       game_over,
  output logic [1:0]                 winner,
  output sched_state_e               dbg_state
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  sched_state_e      state, state_nxt;
  logic [TICK_W-1:0] cnt;
  logic [LEN_W-1:0]  idx, l1, l2, lmax, last;
  logic              hit1, hit2;
  logic [NUM_LEN-1:0] head1, head2, seg1, seg2;
  logic              tick_done, scan_last;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  assign head1 = snake1[NUM_LEN-1:0];
  assign head2 = snake2[NUM_LEN-1:0];

  snake_seg_mux #(.MAX_LEN(MAX_LEN), .NUM_LEN(NUM_LEN), .LEN_W(LEN_W)) u_mux1 (
    .body (snake1),
    .idx  (idx),
    .seg  (seg1)
  );

  snake_seg_mux #(.MAX_LEN(MAX_LEN), .NUM_LEN(NUM_LEN), .LEN_W(LEN_W)) u_mux2 (
    .body (snake2),
    .idx  (idx),
    .seg  (seg2)
  );

  // Scan runs to the longer snake; two empty snakes still take one scan cycle.
  assign lmax      = (l1 > l2) ? l1 : l2;
  assign last      = (lmax == '0) ? '0 : lmax - LEN_W'(1);
  assign scan_last = (idx == last);
  assign tick_done = !pause && (cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_WAIT_TICK;
      S_WAIT_TICK: if (tick_done) state_nxt = S_MOVE;
      S_MOVE:      state_nxt = S_SETTLE;
      S_SETTLE:    state_nxt = S_SCAN;
      S_SCAN:      if (scan_last) state_nxt = S_RESOLVE;
      S_RESOLVE:   state_nxt = (hit1 || hit2) ? S_OVER : S_WAIT_TICK;
      S_OVER:      if (start) state_nxt = S_WAIT_TICK;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    move_en   = (state == S_MOVE);
    busy      = (state == S_MOVE) || (state == S_SETTLE) ||
                (state == S_SCAN) || (state == S_RESOLVE);
    game_over = (state == S_OVER);
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      l1     <= '0;
      l2     <= '0;
      hit1   <= 1'b0;
      hit2   <= 1'b0;
      dead1  <= 1'b0;
      dead2  <= 1'b0;
      winner <= WIN_NONE;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            cnt    <= '0;
            dead1  <= 1'b0;
            dead2  <= 1'b0;
            winner <= WIN_NONE;
          end
        end
        S_WAIT_TICK: begin
          if (!pause) cnt <= (cnt == TICK_LAST) ? '0 : cnt + TICK_W'(1);
        end
        S_SETTLE: begin
          l1   <= clamp_len(len1);
          l2   <= clamp_len(len2);
          hit1 <= 1'b0;
          hit2 <= 1'b0;
          idx  <= '0;
        end
        S_SCAN: begin
          // Cross-body hits include the other head; self hits skip index 0.
          if ((head1 == seg2) && (idx < l2))                    hit1 <= 1'b1;
          if ((head2 == seg1) && (idx < l1))                    hit2 <= 1'b1;
          if ((head1 == seg1) && (idx != '0) && (idx < l1))     hit1 <= 1'b1;
          if ((head2 == seg2) && (idx != '0) && (idx < l2))     hit2 <= 1'b1;
          if (!scan_last) idx <= idx + LEN_W'(1);
        end
        S_RESOLVE: begin
          dead1 <= hit1;
          dead2 <= hit2;
          if (hit1 && hit2) winner <= WIN_DRAW;
          else if (hit1)    winner <= WIN_P2;
          else if (hit2)    winner <= WIN_P1;
          else              winner <= WIN_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule
